instruction_fetch_queue: RTL and testbench

//  Fetch stage directly downstream of the PC register. Takes each new PC address, issues one

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 59 +++++
 rtl/instruction_fetch_queue.sv | 120 ++++++++++++
 tb/tb_instruction_fetch_queue.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : request FSM state (IDLE / WAIT / DRAIN)
//   fetch_entry_t : one buffered fetch, {pc, instr}
//   FETCH_ADDR_WIDTH / FETCH_DATA_WIDTH : entry field widths; the top-level
//     ADDR_WIDTH / DATA_WIDTH parameters default to these and must match them.
//   IMEM_MIN_LATENCY : imemRvalid arrives no earlier than this many cycles after imemReq.
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH = 32;
  localparam int FETCH_DATA_WIDTH = 32;
  localparam int IMEM_MIN_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // ready to accept a new PC
    WAIT  = 2'd1,  // one read outstanding, response will be queued
    DRAIN = 2'd2   // read outstanding but flushed; response will be dropped
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch_entry_t.
// Ports:
//   clock, reset_n : rising-edge clock, async active-low reset
//   push, push_entry : write push_entry at the tail this cycle
//   pop            : retire the head this cycle (caller guarantees count != 0)
//   clear          : empty the queue; wins over push and pop
//   head           : entry at the read pointer (meaningful only when count != 0)
//   count          : number of valid entries, 0..DEPTH
// Pointers are log2(DEPTH) bits and wrap naturally, so DEPTH must be a power of two.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             clear,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Push and pop together leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while count != 0.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage between the PC register and decode. Each accepted PC issues one
// instruction-memory read; the returned {pc, instruction} pair is buffered in
// fetch_queue for decode. A flush (taken branch) empties the queue and causes
// the in-flight response, if any, to be dropped.
// Ports:
//   clock, reset_n          : rising-edge clock, async active-low reset
//   pcAddress, pcValid      : fetch request from the PC register
//   fetchStall              : PC must hold; request not accepted this cycle
//   flush                   : drop queue contents and the in-flight fetch
//   imemReq, imemAddr       : one-cycle read strobe; address held until response
//   imemRvalid, imemRdata   : read response, at least one cycle after imemReq
//   instrValid, instruction, instrPc, decodeReady : queue head to decode
//   dbgState, dbgCount      : FSM state and queue occupancy, for observation
// Handshakes: PC side transfers when pcValid & !fetchStall (fetchStall is the
// inverse of ready and may depend on flush in the same cycle); decode side
// transfers when instrValid & decodeReady & !flush. instrValid, instruction and
// instrPc hold steady while instrValid & !decodeReady.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter  int DATA_WIDTH = FETCH_DATA_WIDTH,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] pcAddress,
  input  logic                  pcValid,
  output logic                  fetchStall,
  input  logic                  flush,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemRvalid,
  input  logic [DATA_WIDTH-1:0] imemRdata,
  output logic                  instrValid,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] instrPc,
  input  logic                  decodeReady,
  output fetch_state_t          dbgState,
  output logic [CNT_W-1:0]      dbgCount
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic. A response arriving in IDLE is stray and ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT: begin
        if (imemRvalid)  state_next = IDLE;
        else if (flush)  state_next = DRAIN;
      end
      DRAIN:   if (imemRvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode. Requests are only issued with a free slot, so a
  // response in WAIT always has room; flush overrides accept, push and pop.
  always_comb begin
    fetchStall = flush | (state != IDLE) | (count == FULL_COUNT);
    accept     = pcValid & ~fetchStall;
    push       = imemRvalid & (state == WAIT) & ~flush;
    pop        = instrValid & decodeReady & ~flush;
  end

  // Memory request: strobe for one cycle, address held until the next accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      imemReq  <= 1'b0;
      imemAddr <= '0;
    end else begin
      imemReq <= accept;
      if (accept) imemAddr <= pcAddress;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = imemAddr;
    push_entry.instr = imemRdata;
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (flush),
    .head       (head),
    .count      (count)
  );

  // Head fields are zeroed when empty so the decode-facing outputs are 0 after reset.
  assign instrValid  = (count != '0);
  assign instruction = instrValid ? head.instr : '0;
  assign instrPc     = instrValid ? head.pc    : '0;

  assign dbgState = state;
  assign dbgCount = count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [31:0]  pcAddress;
  logic         pcValid;
  logic         fetchStall;
  logic         flush;
  logic         imemReq;
  logic [31:0]  imemAddr;
  logic         imemRvalid;
  logic [31:0]  imemRdata;
  logic         instrValid;
  logic [31:0]  instruction;
  logic [31:0]  instrPc;
  logic         decodeReady;
  fetch_state_t dbgState;
  logic [2:0]   dbgCount;

  instruction_fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pcAddress   (pcAddress),
    .pcValid     (pcValid),
    .fetchStall  (fetchStall),
    .flush       (flush),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemRvalid  (imemRvalid),
    .imemRdata   (imemRdata),
    .instrValid  (instrValid),
    .instruction (instruction),
    .instrPc     (instrPc),
    .decodeReady (decodeReady),
    .dbgState    (dbgState),
    .dbgCount    (dbgCount)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];  // expected {pc, instruction} in decode order

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic pv, input logic [31:0] pa, input logic fl,
                       input logic rv, input logic [31:0] rd, input logic dr);
    pcValid     = pv;
    pcAddress   = pa;
    flush       = fl;
    imemRvalid  = rv;
    imemRdata   = rd;
    decodeReady = dr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One fetch with memory latency lat (cycles from imemReq to imemRvalid).
  // If pop_at_resp is set, decode consumes the head in the response cycle.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                           input int lat, input logic pop_at_resp);
    logic [63:0] exp_head;
    drive(1'b1, addr, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("fetch_accept_stall", fetchStall, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("fetch_req_strobe", imemReq, 1'b1);
    check("fetch_req_addr", imemAddr, addr);
    for (int k = 0; k < lat; k++) tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, data, pop_at_resp);
    #1;
    if (pop_at_resp) begin
      check("pushpop_head_valid", instrValid, 1'b1);
      if (exp_q.size() > 0) begin
        exp_head = exp_q.pop_front();
        check("pushpop_head", {instrPc, instruction}, exp_head);
      end else begin
        check("pushpop_scoreboard_empty", 1'b1, 1'b0);
      end
    end
    exp_q.push_back({addr, data});
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Consume n entries and compare each head against the scoreboard.
  task automatic drain_check(input int n);
    logic [63:0] exp_head;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      check("drain_valid", instrValid, 1'b1);
      if (exp_q.size() > 0) begin
        exp_head = exp_q.pop_front();
        check("drain_head", {instrPc, instruction}, exp_head);
      end else begin
        check("drain_scoreboard_empty", 1'b1, 1'b0);
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         pv;
    logic [31:0]  pa;
    logic         fl;
    logic         rv;
    logic [31:0]  rd;
    logic         dr;
    logic         e_stall;
    logic         e_req;
    logic [31:0]  e_addr;
    logic         e_valid;
    logic [31:0]  e_instr;
    logic [31:0]  e_pc;
    fetch_state_t e_state;
    logic [2:0]   e_count;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic pv, input logic [31:0] pa, input logic fl,
                              input logic rv, input logic [31:0] rd, input logic dr,
                              input logic e_stall, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input fetch_state_t e_state,
                              input logic [2:0] e_count);
    vec_t v;
    v.pv = pv; v.pa = pa; v.fl = fl; v.rv = rv; v.rd = rd; v.dr = dr;
    v.e_stall = e_stall; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_state = e_state; v.e_count = e_count;
    return v;
  endfunction

  initial begin
    // Single fetch, latency 1: accept c0, imemReq c1, imemRvalid c2, instrValid c3.
    vecs[0]  = mk(1, 32'h400, 0, 0, 32'h0,        0, 0, 0, 32'h0,   0, 32'h0,        32'h0,   IDLE,  3'd0);
    vecs[1]  = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 1, 32'h400, 0, 32'h0,        32'h0,   WAIT,  3'd0);
    vecs[2]  = mk(0, 32'h0,   0, 1, 32'h8C080004, 0, 1, 0, 32'h400, 0, 32'h0,        32'h0,   WAIT,  3'd0);
    vecs[3]  = mk(0, 32'h0,   0, 0, 32'h0,        1, 0, 0, 32'h400, 1, 32'h8C080004, 32'h400, IDLE,  3'd1);
    vecs[4]  = mk(0, 32'h0,   0, 0, 32'h0,        0, 0, 0, 32'h400, 0, 32'h0,        32'h0,   IDLE,  3'd0);
    // Flush in WAIT: fetch 0x10, flush after imemReq, response 2 cycles later is dropped;
    // 0x80 is held off through DRAIN and accepted back in IDLE.
    vecs[5]  = mk(1, 32'h10,  0, 0, 32'h0,        0, 0, 0, 32'h400, 0, 32'h0,        32'h0,   IDLE,  3'd0);
    vecs[6]  = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 1, 32'h10,  0, 32'h0,        32'h0,   WAIT,  3'd0);
    vecs[7]  = mk(0, 32'h0,   1, 0, 32'h0,        0, 1, 0, 32'h10,  0, 32'h0,        32'h0,   WAIT,  3'd0);
    vecs[8]  = mk(1, 32'h80,  0, 0, 32'h0,        0, 1, 0, 32'h10,  0, 32'h0,        32'h0,   DRAIN, 3'd0);
    vecs[9]  = mk(1, 32'h80,  0, 1, 32'hBAD0BAD0, 0, 1, 0, 32'h10,  0, 32'h0,        32'h0,   DRAIN, 3'd0);
    vecs[10] = mk(1, 32'h80,  0, 0, 32'h0,        0, 0, 0, 32'h10,  0, 32'h0,        32'h0,   IDLE,  3'd0);
    vecs[11] = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 1, 32'h80,  0, 32'h0,        32'h0,   WAIT,  3'd0);
    vecs[12] = mk(0, 32'h0,   0, 1, 32'h11112222, 0, 1, 0, 32'h80,  0, 32'h0,        32'h0,   WAIT,  3'd0);
    vecs[13] = mk(0, 32'h0,   0, 0, 32'h0,        1, 0, 0, 32'h80,  1, 32'h11112222, 32'h80,  IDLE,  3'd1);
    vecs[14] = mk(0, 32'h0,   0, 0, 32'h0,        0, 0, 0, 32'h80,  0, 32'h0,        32'h0,   IDLE,  3'd0);

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // ---- Reset: outputs zero, then reset mid-WAIT and a stray response ----
    #2;
    check("rst_stall", fetchStall, 1'b0);
    check("rst_req", imemReq, 1'b0);
    check("rst_addr", imemAddr, 32'h0);
    check("rst_valid", instrValid, 1'b0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc", instrPc, 32'h0);
    check("rst_state", dbgState, IDLE);
    check("rst_count", dbgCount, 3'd0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("pre_rst_state_wait", dbgState, WAIT);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_state", dbgState, IDLE);
    check("midrst_req", imemReq, 1'b0);
    check("midrst_addr", imemAddr, 32'h0);
    check("midrst_valid", instrValid, 1'b0);
    #1 reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("stray_rsp_valid", instrValid, 1'b0);
    check("stray_rsp_count", dbgCount, 3'd0);
    check("stray_rsp_state", dbgState, IDLE);

    // ---- Table: single fetch and flush-in-WAIT ----
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].pv, vecs[i].pa, vecs[i].fl, vecs[i].rv, vecs[i].rd, vecs[i].dr);
      #1;
      check($sformatf("vec%0d_stall", i), fetchStall, vecs[i].e_stall);
      check($sformatf("vec%0d_req", i), imemReq, vecs[i].e_req);
      check($sformatf("vec%0d_addr", i), imemAddr, vecs[i].e_addr);
      check($sformatf("vec%0d_valid", i), instrValid, vecs[i].e_valid);
      check($sformatf("vec%0d_instr", i), instruction, vecs[i].e_instr);
      check($sformatf("vec%0d_pc", i), instrPc, vecs[i].e_pc);
      check($sformatf("vec%0d_state", i), dbgState, vecs[i].e_state);
      check($sformatf("vec%0d_count", i), dbgCount, vecs[i].e_count);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // ---- Fill to DEPTH, 5th request refused, one pop re-opens ----
    for (int i = 0; i < DEPTH; i++)
      fetch_one(32'(4 * i), 32'hA000_0000 + 32'(i), 1, 1'b0);
    #1;
    check("full_count", dbgCount, 3'd4);
    check("full_stall", fetchStall, 1'b1);
    check("full_head", {instrPc, instruction}, {32'h0, 32'hA000_0000});
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    #1;
    check("full_no_req", imemReq, 1'b0);
    check("full_state_idle", dbgState, IDLE);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    check("full_pop_stall", fetchStall, 1'b1);
    check("full_pop_head", {instrPc, instruction}, exp_q.pop_front());
    tick();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("after_pop_count", dbgCount, 3'd3);
    check("after_pop_stall", fetchStall, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("after_pop_req", imemReq, 1'b1);
    check("after_pop_addr", imemAddr, 32'h10);
    exp_q.push_back({32'h10, 32'hA000_0004});
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0004, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("refill_count", dbgCount, 3'd4);
    drain_check(4);
    #1;
    check("fill_drained_valid", instrValid, 1'b0);

    // ---- Push and pop together at count=2, latency 3, across pointer wrap ----
    fetch_one(32'h200, 32'hB000_0000, 1, 1'b0);
    fetch_one(32'h204, 32'hB000_0001, 1, 1'b0);
    #1;
    check("pp_count_before", dbgCount, 3'd2);
    fetch_one(32'h208, 32'hB000_0002, 3, 1'b1);
    #1;
    check("pp_count_after1", dbgCount, 3'd2);
    fetch_one(32'h20C, 32'hB000_0003, 3, 1'b1);
    #1;
    check("pp_count_after2", dbgCount, 3'd2);
    drain_check(2);

    // ---- Flush together with imemRvalid at count=3, decodeReady=1 ----
    fetch_one(32'h300, 32'hC000_0000, 1, 1'b0);
    fetch_one(32'h304, 32'hC000_0001, 1, 1'b0);
    fetch_one(32'h308, 32'hC000_0002, 1, 1'b0);
    drive(1'b1, 32'h30C, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("fl_accept_stall", fetchStall, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("fl_req", imemReq, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hC000_0003, 1'b1);
    #1;
    check("fl_stall", fetchStall, 1'b1);
    check("fl_count_before", dbgCount, 3'd3);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("fl_count_after", dbgCount, 3'd0);
    check("fl_valid_after", instrValid, 1'b0);
    check("fl_state_after", dbgState, IDLE);
    check("fl_stall_after", fetchStall, 1'b0);
    exp_q.delete();

    // Flush in IDLE with an empty queue changes nothing.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check("idle_flush_stall", fetchStall, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("idle_flush_state", dbgState, IDLE);
    check("idle_flush_count", dbgCount, 3'd0);

    // Normal operation resumes after flushes.
    fetch_one(32'h500, 32'h5555_AAAA, 1, 1'b0);
    drain_check(1);
    #1;
    check("final_valid", instrValid, 1'b0);

    // ---- report ----
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
